// File: rtl/eth_dist_ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_dist_ram_fifo_pkg
//  Brief    : Shared default sizing for the Ethernet distributed-RAM FIFOs.
//  Revision : 1.0 - initial release
// ============================================================================
package eth_dist_ram_fifo_pkg;

    localparam int c_eth_fifo_data_width = 32;
    localparam int c_eth_fifo_depth      = 16;

endpackage : eth_dist_ram_fifo_pkg
`default_nettype wire

// File: rtl/eth_dist_ram_dp.sv
`default_nettype none
// ============================================================================
//  Module   : eth_dist_ram_dp
//  Brief    : Generic LUT-RAM, one synchronous write port, one async read port.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_dist_ram_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    // No reset on the array so it stays mappable to distributed RAM.
    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= din;
        end
    end

    assign dout = r_mem[raddr];

endmodule : eth_dist_ram_dp
`default_nettype wire

// File: rtl/eth_dist_ram_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : eth_dist_ram_fifo
//  Brief    : Shallow synchronous FIFO on distributed RAM with occupancy,
//             threshold flags, flush and sticky overflow/underflow.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_dist_ram_fifo
    import eth_dist_ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_eth_fifo_data_width,
    parameter int DEPTH      = c_eth_fifo_depth,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   cnt,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] c_depth  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_afull  = (ADDR_WIDTH+1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0] c_aempty = (ADDR_WIDTH+1)'(AEMPTY_LVL);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_full  = (r_cnt == c_depth);
    assign w_empty = (r_cnt == '0);

    // When full, a concurrent pop frees the slot the push lands in.
    assign w_push = write && (!w_full || read);
    assign w_pop  = read && !w_empty;

    eth_dist_ram_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (w_push && !clear),
        .waddr (r_wr_ptr),
        .din   (data_in),
        .raddr (r_rd_ptr),
        .dout  (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
                r_data_out <= w_rd_data;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (ADDR_WIDTH+1)'(1);
                2'b01:   r_cnt <= r_cnt - (ADDR_WIDTH+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (write && w_full && !read) begin
                r_overflow <= 1'b1;
            end
            if (read && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign data_out     = r_data_out;
    assign cnt          = r_cnt;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_cnt >= c_afull);
    assign almost_empty = (r_cnt <= c_aempty);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : eth_dist_ram_fifo
`default_nettype wire

// File: tb/tb_eth_dist_ram_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_dist_ram_fifo
//  Brief    : Directed self-checking bench for eth_dist_ram_fifo (32x16 and 8x4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_dist_ram_fifo;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        write;
    logic        read;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  cnt;

    logic        s_clear, s_write, s_read;
    logic [7:0]  s_din, s_dout;
    logic        s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [2:0]  s_cnt;

    int tests;
    int failed;

    eth_dist_ram_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .write        (write),
        .data_in      (data_in),
        .read         (read),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .cnt          (cnt),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    eth_dist_ram_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (4)
    ) dut_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (s_clear),
        .write        (s_write),
        .data_in      (s_din),
        .read         (s_read),
        .data_out     (s_dout),
        .full         (s_full),
        .empty        (s_empty),
        .almost_full  (s_af),
        .almost_empty (s_ae),
        .cnt          (s_cnt),
        .overflow     (s_ovf),
        .underflow    (s_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; write = 1'b0; read = 1'b0; data_in = '0;
        s_clear = 1'b0; s_write = 1'b0; s_read = 1'b0; s_din = '0;
        #12;
        tests++;
        if ({cnt, empty, almost_empty, full, almost_full, overflow, underflow} !== {5'd0, 6'b110000}) begin
            failed++;
            $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b un=%b expected cnt=0 e=1 ae=1 f=0 af=0 ov=0 un=0",
                     cnt, empty, almost_empty, full, almost_full, overflow, underflow);
        end
        tests++;
        if (data_out !== 32'h0) begin
            failed++;
            $display("FAIL reset_data_out: got %h expected 00000000", data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tests++;
        if ({cnt, empty, almost_empty, full, data_out} !== {5'd0, 3'b110, 32'h0}) begin
            failed++;
            $display("FAIL idle_after_reset: got cnt=%0d e=%b ae=%b f=%b dout=%h expected cnt=0 e=1 ae=1 f=0 dout=0",
                     cnt, empty, almost_empty, full, data_out);
        end
    endtask

    task automatic test_fill_drain;
        logic [8:0] exp;
        for (int i = 1; i <= 16; i++) begin
            write = 1'b1; data_in = 32'(i);
            tick();
            exp = {5'(i), (i == 16), 1'b0, (i >= 14), (i <= 2)};
            tests++;
            if ({cnt, full, empty, almost_full, almost_empty} !== exp) begin
                failed++;
                $display("FAIL fill_%0d: got cnt/f/e/af/ae=%b expected %b", i,
                         {cnt, full, empty, almost_full, almost_empty}, exp);
            end
        end
        write = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            read = 1'b1;
            tick();
            tests++;
            if (data_out !== 32'(i) || cnt !== 5'(16 - i)) begin
                failed++;
                $display("FAIL drain_%0d: got dout=%h cnt=%0d expected dout=%h cnt=%0d",
                         i, data_out, cnt, 32'(i), 16 - i);
            end
        end
        read = 1'b0;
        tests++;
        if (empty !== 1'b1 || almost_empty !== 1'b1) begin
            failed++;
            $display("FAIL drain_end_empty: got e=%b ae=%b expected 1 1", empty, almost_empty);
        end
    endtask

    task automatic test_full_rw;
        logic [31:0] exp_d;
        for (int i = 1; i <= 16; i++) begin
            write = 1'b1; data_in = 32'h100 + 32'(i);
            tick();
        end
        write = 1'b1; read = 1'b1; data_in = 32'hDEADBEEF;
        tick();
        write = 1'b0; read = 1'b0;
        tests++;
        if (cnt !== 5'd16 || full !== 1'b1 || data_out !== 32'h101) begin
            failed++;
            $display("FAIL full_rw: got cnt=%0d f=%b dout=%h expected cnt=16 f=1 dout=00000101",
                     cnt, full, data_out);
        end
        for (int i = 0; i < 16; i++) begin
            read = 1'b1;
            tick();
            exp_d = (i == 15) ? 32'hDEADBEEF : 32'h102 + 32'(i);
            tests++;
            if (data_out !== exp_d) begin
                failed++;
                $display("FAIL full_rw_drain_%0d: got %h expected %h", i, data_out, exp_d);
            end
        end
        read = 1'b0;
    endtask

    task automatic test_overflow_underflow;
        read = 1'b1;
        tick();
        read = 1'b0;
        tests++;
        if (underflow !== 1'b1 || overflow !== 1'b0 || cnt !== 5'd0 || data_out !== 32'hDEADBEEF) begin
            failed++;
            $display("FAIL underflow: got un=%b ov=%b cnt=%0d dout=%h expected 1 0 0 deadbeef",
                     underflow, overflow, cnt, data_out);
        end
        for (int i = 1; i <= 16; i++) begin
            write = 1'b1; data_in = 32'h200 + 32'(i);
            tick();
        end
        data_in = 32'hCAFEF00D;
        tick();
        write = 1'b0;
        tests++;
        if (overflow !== 1'b1 || cnt !== 5'd16) begin
            failed++;
            $display("FAIL overflow: got ov=%b cnt=%0d expected ov=1 cnt=16", overflow, cnt);
        end
        for (int i = 1; i <= 16; i++) begin
            read = 1'b1;
            tick();
            tests++;
            if (data_out !== 32'h200 + 32'(i)) begin
                failed++;
                $display("FAIL ovf_drain_%0d: got %h expected %h", i, data_out, 32'h200 + 32'(i));
            end
        end
        read = 1'b0;
        tests++;
        if ({overflow, underflow, empty} !== 3'b111) begin
            failed++;
            $display("FAIL sticky_flags: got ov/un/e=%b expected 111", {overflow, underflow, empty});
        end
    endtask

    task automatic test_clear;
        for (int i = 1; i <= 6; i++) begin
            write = 1'b1; data_in = 32'h300 + 32'(i);
            tick();
        end
        write = 1'b0; read = 1'b1;
        tick();
        tests++;
        if (cnt !== 5'd5 || data_out !== 32'h301) begin
            failed++;
            $display("FAIL pre_clear: got cnt=%0d dout=%h expected cnt=5 dout=00000301", cnt, data_out);
        end
        clear = 1'b1; write = 1'b1; read = 1'b1; data_in = 32'h12345678;
        tick();
        clear = 1'b0; write = 1'b0; read = 1'b0;
        tests++;
        if ({cnt, empty, overflow, underflow, data_out} !== {5'd0, 3'b100, 32'h301}) begin
            failed++;
            $display("FAIL clear: got cnt=%0d e=%b ov=%b un=%b dout=%h expected 0 1 0 0 00000301",
                     cnt, empty, overflow, underflow, data_out);
        end
        write = 1'b1; data_in = 32'h00000ABC;
        tick();
        write = 1'b0; read = 1'b1;
        tick();
        read = 1'b0;
        tests++;
        if (data_out !== 32'h00000ABC || cnt !== 5'd0) begin
            failed++;
            $display("FAIL after_clear: got dout=%h cnt=%0d expected 00000abc 0", data_out, cnt);
        end
    endtask

    task automatic test_empty_rw;
        write = 1'b1; read = 1'b1; data_in = 32'h55;
        tick();
        write = 1'b0; read = 1'b0;
        tests++;
        if (cnt !== 5'd1 || empty !== 1'b0 || underflow !== 1'b1 || data_out !== 32'h00000ABC) begin
            failed++;
            $display("FAIL empty_rw: got cnt=%0d e=%b un=%b dout=%h expected 1 0 1 00000abc",
                     cnt, empty, underflow, data_out);
        end
        read = 1'b1;
        tick();
        read = 1'b0;
        tests++;
        if (data_out !== 32'h55 || empty !== 1'b1) begin
            failed++;
            $display("FAIL empty_rw_pop: got dout=%h e=%b expected 00000055 1", data_out, empty);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_async_reset;
        for (int i = 1; i <= 3; i++) begin
            write = 1'b1; data_in = 32'h400 + 32'(i);
            tick();
        end
        write = 1'b0; read = 1'b1;
        tick();
        read = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cnt, empty, data_out} !== {5'd0, 1'b1, 32'h0}) begin
            failed++;
            $display("FAIL async_reset: got cnt=%0d e=%b dout=%h expected 0 1 00000000", cnt, empty, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sweep;
        logic [7:0] q[$];
        logic [7:0] exp_d;
        logic       do_push, do_pop;
        int         wp;
        int         errs;
        exp_d = 8'h00;
        errs  = 0;
        for (int c = 0; c < 1000; c++) begin
            wp = ((c / 50) % 2 == 0) ? 75 : 25;
            s_write = ($urandom_range(0, 99) < wp);
            s_read  = ($urandom_range(0, 99) >= wp);
            if ($urandom_range(0, 9) == 0) s_read = 1'b1;
            s_din   = 8'($urandom);
            do_push = s_write && (q.size() < 4 || s_read);
            do_pop  = s_read && q.size() != 0;
            if (do_pop) begin
                exp_d = q[0];
                void'(q.pop_front());
            end
            if (do_push) q.push_back(s_din);
            tick();
            tests++;
            if (s_dout !== exp_d || s_cnt !== 3'(q.size()) ||
                s_full !== (q.size() == 4) || s_empty !== (q.size() == 0)) begin
                failed++;
                errs++;
                if (errs <= 10)
                    $display("FAIL sweep_%0d: got dout=%h cnt=%0d f=%b e=%b expected dout=%h cnt=%0d",
                             c, s_dout, s_cnt, s_full, s_empty, exp_d, q.size());
            end
        end
        s_write = 1'b0; s_read = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_overflow_underflow();
        test_clear();
        test_empty_rw();
        test_async_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_eth_dist_ram_fifo
`default_nettype wire

// File: doc/eth_dist_ram_fifo.md
# eth_dist_ram_fifo

Parametrised synchronous FIFO built on a generic dual-port distributed RAM with one write port and one asynchronous read port. It replaces fixed 16x32 LUT-RAM instances with a width/depth-generic buffer. It adds pointer management, occupancy count, almost-full/almost-empty thresholds, flush, and sticky overflow/underflow flags. It sits between the Wishbone-side DMA logic and the MAC TX/RX datapaths wherever a shallow elastic buffer is needed.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width in bits, ≥1.
- `DEPTH`, 16: number of words; power of two, ≥4.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: derived; do not override.
- `AFULL_LVL`, `DEPTH-2`: `almost_full` asserts when `cnt >= AFULL_LVL`.
- `AEMPTY_LVL`, 2: `almost_empty` asserts when `cnt <= AEMPTY_LVL`.

Ports:
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset is asynchronous and active-low.
- `clear`, input, 1: synchronous flush.
- `write`, input, 1: push request.
- `data_in`, input, DATA_WIDTH: push data.
- `read`, input, 1: pop request.
- `data_out`, output, DATA_WIDTH: registered pop data.
- `full`, output, 1: `cnt == DEPTH`.
- `empty`, output, 1: `cnt == 0`.
- `almost_full`, output, 1: see `AFULL_LVL`.
- `almost_empty`, output, 1: see `AEMPTY_LVL`.
- `cnt`, output, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `overflow`, output, 1: sticky; set by a write while full.
- `underflow`, output, 1: sticky; set by a read while empty.

## Operation
- Storage: DEPTH x DATA_WIDTH array held in the RAM sub-module. Writes are synchronous; reads are asynchronous. The array is not reset and its contents are undefined after reset.
- Write pointer `wr_ptr` and read pointer `rd_ptr` are ADDR_WIDTH bits each and wrap naturally at DEPTH.
- Push accepted when `write && !full`, or when `write && full && read`. An accepted push stores `data_in` at `wr_ptr` and increments `wr_ptr`.
- Pop accepted when `read && !empty`. An accepted pop loads `data_out <= mem[rd_ptr]` and increments `rd_ptr`. If no pop is accepted, `data_out` holds its value.
- Count update:
  - `cnt` +1 on push only.
  - `cnt` -1 on pop only.
  - `cnt` unchanged when both or neither are accepted.
- Simultaneous read and write:
  - Empty: only the write is accepted. `underflow` sets; `empty` deasserts next cycle. There is no fall-through.
  - Full: both are accepted and `cnt` stays at DEPTH. The popped word is the oldest entry.
- Rejected operations:
  - Write while full without read: data is dropped, pointers unchanged, `overflow` <= 1.
  - Read while empty: pointers unchanged, `data_out` holds, `underflow` <= 1.
- `clear` has priority over read and write in the same cycle. It sets `wr_ptr`, `rd_ptr`, `cnt`, `overflow` and `underflow` to 0. `data_out` holds; RAM contents are untouched.
- Flags are combinational decodes of registered `cnt`. There is no other state machine beyond the pointer/count registers.

## Timing
- Reset values: `data_out` = 0, `cnt` = 0, `empty` = 1, `almost_empty` = 1, `full` = 0, `almost_full` = 0, `overflow` = 0, `underflow` = 0.
- Reset asserted mid-operation takes effect immediately (asynchronous) and discards all queued words.
- Write-to-read latency: a word written in cycle N makes `empty` deassert after edge N+1. It is readable by `read` in cycle N+1 and appears on `data_out` after edge N+2.
- Read latency: a pop in cycle N presents its data on `data_out` after edge N+1.
- Flags and `cnt` reflect accepted operations one edge later.
- Single clock domain; no CDC.

## Structure
- Sub-module `eth_dist_ram_dp`, parameters DATA_WIDTH and ADDR_WIDTH:
  - Ports: `clk`, `we`, `waddr`, `din`, `raddr`, `dout`.
  - Synchronous write, asynchronous read, no reset.
  - It maps to LUT-RAM and replaces the fixed RAM16X1D arrays.
- Shared constants (default `DATA_WIDTH`, default `DEPTH`) go in the ethernet defines file. No typedefs.

## Test plan
- Reset, then idle: `empty`=1, `almost_empty`=1, `cnt`=0, `data_out`=0, `full`=0.
- Push 0x00000001..0x00000010 (16 writes), then pop 16: `full`=1 after the 16th push, `almost_full` asserted at `cnt`=14, pops return 1..16 in order, `empty`=1 at end.
- With the FIFO full, assert write=1 and read=1 with `data_in`=0xDEADBEEF for one cycle: `cnt` stays 16, `data_out`=oldest word, 0xDEADBEEF returned last after draining.
- Write while full (0xCAFEF00D) and read while empty: the data is never returned, `overflow`=1 and `underflow`=1 and both stay set until `clear`.
- With `cnt`=5, assert `clear` together with write and read: next cycle `cnt`=0, `empty`=1, flags 0, `data_out` unchanged.
- Parameter sweep DATA_WIDTH=8, DEPTH=4: run 1000 cycles of random push/pop against a scoreboard with pointer wrap exercised; no mismatches, and `cnt` always equals the scoreboard depth.
